// File: rtl/btn_pkg.sv
// Shared encodings for the push-button debounce/toggle front end.
// State values are fixed so the FSM can be probed by encoding.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous switch inputs.
// Both stages clear on a synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_debounce_toggle.sv
// Debounces a raw push-button, emits one t_pulse per press,
// flags long presses and mirrors the downstream toggle state.
module btn_debounce_toggle
  import btn_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 60000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic t_pulse,
  output logic long_press,
  output logic toggle_q,
  output logic busy
);

  if (DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES < 1 ||
      LONG_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_long
    $error("LONG_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX =
    CNT_W'(LONG_CYCLES);

  logic btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             tog_q, tog_d;
  logic             pulse_q, pulse_d;
  logic             long_q, long_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    tog_d   = tog_q;
    pulse_d = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_DB_PRESS;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
          tog_d   = ~tog_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_DB_RELEASE;
          cnt_d   = ONE;
        end else begin
          long_d = (cnt_q == LONG_LAST);
          // saturate so long_press cannot repeat
          if (cnt_q < LONG_MAX) cnt_d = cnt_q + ONE;
        end
      end
      ST_DB_RELEASE: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
          cnt_d   = LONG_MAX;
        end else if (cnt_q >= DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
    busy_d = (state_d == ST_DB_PRESS) ||
             (state_d == ST_DB_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      tog_q   <= 1'b0;
      pulse_q <= 1'b0;
      long_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      tog_q   <= tog_d;
      pulse_q <= pulse_d;
      long_q  <= long_d;
      busy_q  <= busy_d;
    end
  end

  assign btn_level  = level_q;
  assign t_pulse    = pulse_q;
  assign long_press = long_q;
  assign toggle_q   = tog_q;
  assign busy       = busy_q;

endmodule
